// File: rtl/qsys_pio_pkg.sv
// qsys_pio_pkg
//   Shared definitions for the parametrised input PIO.
//   - ADDR_* : Avalon word addresses of the register map
//   - ARM_W  : width of a counter that must hold the value n
package qsys_pio_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_POLAR  = 3'd1;
    localparam logic [2:0] ADDR_MASK   = 3'd2;
    localparam logic [2:0] ADDR_EDGE   = 3'd3;
    localparam logic [2:0] ADDR_ANY    = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;

    // Bits needed to count 0..n inclusive, never less than 1.
    function automatic integer ARM_W(input integer n);
        integer w;
        w = 1;
        while ((1 << w) <= n)
            w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/qsys_pio_debounce.sv
// qsys_pio_debounce
//   Per-bit stability filter. Each output bit takes the input value only
//   after that value has differed from the output for DEBOUNCE_CNT
//   consecutive cycles; any cycle where input equals output restarts the
//   count.
// Ports
//   clk    system clock
//   reset  synchronous, active high; outputs and counters cleared
//   din    synchronised input vector
//   dout   filtered vector
module qsys_pio_debounce #(
    parameter int WIDTH        = 8,
    parameter int DEBOUNCE_CNT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int CW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            logic [CW-1:0] cnt_q;
            logic          out_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= '0;
                    out_q <= 1'b0;
                end else if (din[i] == out_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_LAST) begin
                    // DEBOUNCE_CNT-th consecutive differing cycle: accept.
                    cnt_q <= '0;
                    out_q <= din[i];
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign dout[i] = out_q;
        end
    endgenerate

endmodule

// File: rtl/qsys_pio_in_irq.sv
// qsys_pio_in_irq
//   Avalon-MM input PIO with per-bit edge capture and a level IRQ.
//   Optional build macro PIO_DEBOUNCE_EN inserts a per-bit debounce filter
//   between the synchroniser and the DATA level.
// Ports
//   clk         system clock
//   reset       synchronous, active high
//   address     word address (0 DATA,1 POLAR,2 MASK,3 EDGE,4 ANY,5 STATUS)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    registered read data (1-cycle latency, mux follows address)
//   in_port     asynchronous external inputs
//   irq         level interrupt, active high
module qsys_pio_in_irq
    import qsys_pio_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CNT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    // Edges are suppressed until the reset value of the history flops has
    // flushed through the whole filter path, so inputs already high at
    // reset do not register as a rise.
`ifdef PIO_DEBOUNCE_EN
    localparam int ARM_CYC = SYNC_STAGES + DEBOUNCE_CNT + 1;
    localparam logic [7:0] DB_FIELD = (DEBOUNCE_CNT > 255) ? 8'd255 : 8'(DEBOUNCE_CNT);
`else
    localparam int ARM_CYC = SYNC_STAGES + 1;
    localparam logic [7:0] DB_FIELD = 8'd0;
`endif
    localparam int AW = ARM_W(ARM_CYC);
    localparam logic [AW-1:0] ARM_LAST = AW'(ARM_CYC);

    // ---------------- synchroniser ----------------
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int k = 1; k < SYNC_STAGES; k++)
                sync_q[k] <= sync_q[k-1];
        end
    end

    logic [WIDTH-1:0] filt;

`ifdef PIO_DEBOUNCE_EN
    qsys_pio_debounce #(
        .WIDTH        (WIDTH),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .din   (sync_q[SYNC_STAGES-1]),
        .dout  (filt)
    );
`else
    assign filt = sync_q[SYNC_STAGES-1];
`endif

    // ---------------- edge detect ----------------
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] rise, fall, det;
    logic [AW-1:0]    arm_cnt;
    logic             armed;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q  <= '0;
            arm_cnt <= '0;
        end else begin
            prev_q <= filt;
            if (!armed)
                arm_cnt <= arm_cnt + 1'b1;
        end
    end

    assign armed = (arm_cnt == ARM_LAST);
    assign rise  = filt & ~prev_q;
    assign fall  = ~filt & prev_q;

    logic [WIDTH-1:0] polar_q, mask_q, edge_q, any_q;

    assign det = (any_q & (rise | fall)) | (~any_q & ((polar_q & fall) | (~polar_q & rise)));

    // ---------------- register file ----------------
    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] w1c_mask;
    logic [WIDTH-1:0] edge_nxt;
    logic             unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;
    assign w1c_mask  = (wr && address == ADDR_EDGE) ? wd : '0;
    // A detect in the same cycle as a clear wins, so no event is lost.
    assign edge_nxt  = (det & {WIDTH{armed}}) | (edge_q & ~w1c_mask);

    always_ff @(posedge clk) begin
        if (reset) begin
            polar_q <= '0;
            mask_q  <= '0;
            edge_q  <= '0;
            any_q   <= '0;
            irq     <= 1'b0;
        end else begin
            if (wr && address == ADDR_POLAR) polar_q <= wd;
            if (wr && address == ADDR_MASK)  mask_q  <= wd;
            if (wr && address == ADDR_ANY)   any_q   <= wd;
            edge_q <= edge_nxt;
            irq    <= |(edge_q & mask_q);
        end
    end

    // ---------------- read mux ----------------
    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:   rd_mux[WIDTH-1:0] = filt;
            ADDR_POLAR:  rd_mux[WIDTH-1:0] = polar_q;
            ADDR_MASK:   rd_mux[WIDTH-1:0] = mask_q;
            ADDR_EDGE:   rd_mux[WIDTH-1:0] = edge_q;
            ADDR_ANY:    rd_mux[WIDTH-1:0] = any_q;
            ADDR_STATUS: rd_mux = {DB_FIELD, 8'(SYNC_STAGES), 8'(WIDTH), 7'd0, irq};
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) readdata <= '0;
        else       readdata <= rd_mux;
    end

endmodule

// File: tb/tb_qsys_pio_in_irq.sv
module tb_qsys_pio_in_irq;

    localparam int SYNC = 2;
`ifdef PIO_DEBOUNCE_EN
    localparam int DB = 16;
    localparam logic [31:0] STATUS_EXP = 32'h1002_0800;
`else
    localparam int DB = 0;
    localparam logic [31:0] STATUS_EXP = 32'h0002_0800;
`endif
    localparam int W = SYNC + DB + 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  in_port;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    qsys_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(SYNC), .DEBOUNCE_CNT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        tick();
        d = readdata;
        chipselect = 1'b0;
    endtask

    typedef struct {
        logic        is_wr;
        logic [2:0]  addr;
        logic [31:0] data;   // write data, or expected read value
        string       name;
    } vec_t;

    vec_t vt [17];
    logic [31:0] r;

    initial begin
        vt[0]  = '{1'b0, 3'd0, 32'h0000_005A, "data_level"};
        vt[1]  = '{1'b1, 3'd0, 32'h0000_0012, ""};
        vt[2]  = '{1'b0, 3'd0, 32'h0000_005A, "data_ro"};
        vt[3]  = '{1'b1, 3'd1, 32'hFFFF_FFFF, ""};
        vt[4]  = '{1'b0, 3'd1, 32'h0000_00FF, "polar_rw_trunc"};
        vt[5]  = '{1'b1, 3'd2, 32'h0000_01A5, ""};
        vt[6]  = '{1'b0, 3'd2, 32'h0000_00A5, "mask_rw_trunc"};
        vt[7]  = '{1'b1, 3'd4, 32'h0000_003C, ""};
        vt[8]  = '{1'b0, 3'd4, 32'h0000_003C, "any_rw"};
        vt[9]  = '{1'b0, 3'd3, 32'h0000_0000, "edge_static_cfg"};
        vt[10] = '{1'b1, 3'd5, 32'hFFFF_FFFF, ""};
        vt[11] = '{1'b0, 3'd5, STATUS_EXP,    "status"};
        vt[12] = '{1'b1, 3'd6, 32'hDEAD_BEEF, ""};
        vt[13] = '{1'b0, 3'd6, 32'h0000_0000, "addr6_zero"};
        vt[14] = '{1'b0, 3'd7, 32'h0000_0000, "addr7_zero"};
        vt[15] = '{1'b1, 3'd1, 32'h0000_0000, ""};
        vt[16] = '{1'b0, 3'd1, 32'h0000_0000, "polar_clear"};

        reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = 8'hFF;

        // Reset with inputs high: no spurious edge after release.
        tick(3);
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", {31'd0, irq}, 32'h0);
        reset = 1'b0;
        tick(W + 6);
        rd(3'd3, r); chk("no_edge_after_reset", r, 32'h0);
        chk("irq_after_reset", {31'd0, irq}, 32'h0);
        rd(3'd0, r); chk("data_ff", r, 32'hFF);

        // Register access table (inputs static, only falls: no capture).
        in_port = 8'h5A;
        tick(W);
        for (int i = 0; i < 17; i++) begin
            if (vt[i].is_wr) wr(vt[i].addr, vt[i].data);
            else begin
                rd(vt[i].addr, r);
                chk(vt[i].name, r, vt[i].data);
            end
        end
        wr(3'd2, 32'h0);
        wr(3'd4, 32'h0);

        // Rising edge on bit 0 with MASK=1: exact edge/irq latency.
        in_port = 8'h00;
        tick(W);
        wr(3'd3, 32'hFF);
        wr(3'd2, 32'h1);
        in_port = 8'h01;
        tick(SYNC + 1 + DB);
        chk("irq_not_yet", {31'd0, irq}, 32'h0);
        tick();
        chk("irq_asserted", {31'd0, irq}, 32'h1);
        rd(3'd3, r); chk("edge_bit0", r, 32'h1);
        wr(3'd3, 32'h1);
        chk("irq_lags_clear", {31'd0, irq}, 32'h1);
        tick();
        chk("irq_cleared", {31'd0, irq}, 32'h0);

        // Polarity / any-edge: bit1 falling only, bit2 both edges.
        wr(3'd2, 32'h0);
        wr(3'd1, 32'h2);
        wr(3'd4, 32'h4);
        wr(3'd3, 32'hFF);
        in_port = 8'h07;
        tick(W);
        rd(3'd3, r); chk("edge_after_rise", r, 32'h4);
        in_port = 8'h01;
        tick(W);
        rd(3'd3, r); chk("edge_after_fall", r, 32'h6);

        // Clear in the same cycle as a detect on bit3: set wins.
        wr(3'd1, 32'h0);
        wr(3'd4, 32'h0);
        wr(3'd3, 32'hFF);
        in_port = 8'h09;
        tick(SYNC + DB);
        wr(3'd3, 32'h8);
        rd(3'd3, r); chk("set_wins_w1c", r, 32'h8);
        wr(3'd3, 32'h8);
        rd(3'd3, r); chk("w1c_clears", r, 32'h0);

        // Reset mid-operation returns state and restarts the arm window.
        wr(3'd2, 32'hFF);
        in_port = 8'h19;
        tick(W);
        chk("irq_before_reset", {31'd0, irq}, 32'h1);
        reset = 1'b1;
        tick();
        chk("irq_in_reset", {31'd0, irq}, 32'h0);
        chk("rd_in_reset", readdata, 32'h0);
        reset = 1'b0;
        tick(W + 6);
        rd(3'd2, r); chk("mask_after_reset", r, 32'h0);
        rd(3'd3, r); chk("edge_after_rearm", r, 32'h0);
        rd(3'd0, r); chk("data_after_reset", r, 32'h19);

`ifdef PIO_DEBOUNCE_EN
        // Glitch shorter than the debounce window is rejected.
        in_port = 8'h39;
        tick(10);
        in_port = 8'h19;
        tick(30);
        rd(3'd0, r); chk("db_glitch_data", r, 32'h19);
        rd(3'd3, r); chk("db_glitch_edge", r, 32'h0);
        in_port = 8'h39;
        tick(20 + W);
        rd(3'd0, r); chk("db_level_data", r, 32'h39);
        rd(3'd3, r); chk("db_level_edge", r, 32'h20);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
